// File: rtl/snake_pkg.sv
// Shared grid geometry, direction and FSM encodings for the snake game controller.
package snake_pkg;

  localparam int unsigned GRID_W  = 7;
  localparam int unsigned GRID_H  = 6;
  localparam int unsigned MAX_LEN = 8;

  localparam logic [2:0] START_X = 3'd1;
  localparam logic [2:0] START_Y = 3'd3;

  // Opposite directions differ only in bit 0.
  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2,
    WIN  = 2'd3
  } state_t;

  function automatic dir_t dir_opposite(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/snake_body.sv
// Segment shift register (index 0 = head) with growth control and a registered occupancy bitmap.
module snake_body
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W  = snake_pkg::GRID_W,
  parameter int unsigned GRID_H  = snake_pkg::GRID_H,
  parameter int unsigned MAX_LEN = snake_pkg::MAX_LEN
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       shift_i,
  input  logic                       grow_i,
  input  logic [2:0]                 head_x_i,
  input  logic [2:0]                 head_y_i,
  output logic [MAX_LEN-1:0][2:0]    seg_x_o,
  output logic [MAX_LEN-1:0][2:0]    seg_y_o,
  output logic [3:0]                 len_o,
  output logic [GRID_W*GRID_H-1:0]   occ_o
);

  localparam int unsigned CELLS   = GRID_W * GRID_H;
  localparam int unsigned RST_IDX = 32'(START_Y) * GRID_W + 32'(START_X);
  localparam logic [CELLS-1:0] OCC_RST = {{(CELLS-1){1'b0}}, 1'b1} << RST_IDX;

  logic [MAX_LEN-1:0][2:0] seg_x_q, seg_x_d;
  logic [MAX_LEN-1:0][2:0] seg_y_q, seg_y_d;
  logic [3:0]              len_q, len_d;
  logic [CELLS-1:0]        occ_q, occ_d;
  logic [5:0]              idx;

  always_comb begin
    seg_x_d = seg_x_q;
    seg_y_d = seg_y_q;
    len_d   = len_q;
    occ_d   = '0;
    idx     = '0;
    if (shift_i) begin
      for (int unsigned i = MAX_LEN - 1; i > 0; i--) begin
        seg_x_d[i] = seg_x_q[i-1];
        seg_y_d[i] = seg_y_q[i-1];
      end
      seg_x_d[0] = head_x_i;
      seg_y_d[0] = head_y_i;
      // The old tail shifts into index len_q, so growing just widens the window.
      if (grow_i) begin
        len_d = len_q + 4'd1;
      end
    end
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      idx = 6'(seg_y_d[i]) * 6'(GRID_W) + 6'(seg_x_d[i]);
      if (4'(i) < len_d) begin
        occ_d[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seg_x_q <= {MAX_LEN{START_X}};
      seg_y_q <= {MAX_LEN{START_Y}};
      len_q   <= 4'd1;
      occ_q   <= OCC_RST;
    end else begin
      seg_x_q <= seg_x_d;
      seg_y_q <= seg_y_d;
      len_q   <= len_d;
      occ_q   <= occ_d;
    end
  end

  assign seg_x_o = seg_x_q;
  assign seg_y_o = seg_y_q;
  assign len_o   = len_q;
  assign occ_o   = occ_q;

endmodule

// File: rtl/snake_ctrl.sv
// Snake game controller: FSM, direction handling, wall/self-collision and eat decode.
module snake_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W  = snake_pkg::GRID_W,
  parameter int unsigned GRID_H  = snake_pkg::GRID_H,
  parameter int unsigned MAX_LEN = snake_pkg::MAX_LEN
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic                     i_Tick,
  input  logic                     i_Up,
  input  logic                     i_Down,
  input  logic                     i_Left,
  input  logic                     i_Right,
  input  logic [2:0]               i_Apple_X,
  input  logic [2:0]               i_Apple_Y,
  output logic [2:0]               o_Head_X,
  output logic [2:0]               o_Head_Y,
  output logic [3:0]               o_Length,
  output logic [GRID_W*GRID_H-1:0] o_Occupancy,
  output logic                     o_Eat,
  output logic                     o_Game_Over,
  output logic                     o_Win
);

  state_t state_q;
  dir_t   pend_q, exec_q;
  logic   eat_q, over_q, win_q;

  logic [MAX_LEN-1:0][2:0] seg_x, seg_y;
  logic [3:0]              len;

  logic       btn_any, rev_blocked;
  dir_t       req, pend_eff;
  logic [2:0] hx, hy, nx, ny;
  logic       wall_hit, eat_hit, self_hit;
  logic [3:0] keep_n;
  logic       move, grow;

  always_comb begin
    btn_any = i_Up | i_Down | i_Left | i_Right;
    if (i_Up) begin
      req = UP;
    end else if (i_Down) begin
      req = DOWN;
    end else if (i_Left) begin
      req = LEFT;
    end else begin
      req = RIGHT;
    end
    rev_blocked = (len > 4'd1) && (req == dir_opposite(exec_q));
    // A button in the tick cycle already steers that tick.
    pend_eff = (btn_any && !rev_blocked) ? req : pend_q;

    hx       = seg_x[0];
    hy       = seg_y[0];
    nx       = hx;
    ny       = hy;
    wall_hit = 1'b0;
    case (pend_eff)
      UP: begin
        wall_hit = (hy == 3'd0);
        ny       = hy - 3'd1;
      end
      DOWN: begin
        wall_hit = (hy == 3'(GRID_H - 1));
        ny       = hy + 3'd1;
      end
      LEFT: begin
        wall_hit = (hx == 3'd0);
        nx       = hx - 3'd1;
      end
      RIGHT: begin
        wall_hit = (hx == 3'(GRID_W - 1));
        nx       = hx + 3'd1;
      end
      default: ;
    endcase

    eat_hit = (nx == i_Apple_X) && (ny == i_Apple_Y);
    // Segments that survive the move: the tail cell is vacated unless eating.
    keep_n   = eat_hit ? len : (len - 4'd1);
    self_hit = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ((4'(i) < keep_n) && (seg_x[i] == nx) && (seg_y[i] == ny)) begin
        self_hit = 1'b1;
      end
    end

    move = (state_q == RUN) && i_Tick && !wall_hit && !self_hit;
    grow = move && eat_hit;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= IDLE;
      pend_q  <= RIGHT;
      exec_q  <= RIGHT;
      eat_q   <= 1'b0;
      over_q  <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      eat_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_any) begin
            pend_q  <= req;
            exec_q  <= req;
            state_q <= RUN;
          end
        end
        RUN: begin
          pend_q <= pend_eff;
          if (i_Tick) begin
            exec_q <= pend_eff;
            if (wall_hit || self_hit) begin
              state_q <= OVER;
              over_q  <= 1'b1;
            end else if (eat_hit) begin
              eat_q <= 1'b1;
              if (len == 4'(MAX_LEN - 1)) begin
                state_q <= WIN;
                win_q   <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  snake_body #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .MAX_LEN(MAX_LEN)
  ) u_body (
    .clk_i   (i_Clk),
    .rst_i   (i_Reset),
    .shift_i (move),
    .grow_i  (grow),
    .head_x_i(nx),
    .head_y_i(ny),
    .seg_x_o (seg_x),
    .seg_y_o (seg_y),
    .len_o   (len),
    .occ_o   (o_Occupancy)
  );

  assign o_Head_X    = seg_x[0];
  assign o_Head_Y    = seg_y[0];
  assign o_Length    = len;
  assign o_Eat       = eat_q;
  assign o_Game_Over = over_q;
  assign o_Win       = win_q;

endmodule

// File: tb/tb_snake_ctrl.sv
// Table-driven scoreboard bench for snake_ctrl plus a hand-written reset/eat collision sequence.
module tb_snake_ctrl;

  logic        clk = 1'b0;
  logic        rst, tick, up, down, left, right;
  logic [2:0]  ax, ay;
  logic [2:0]  hx, hy;
  logic [3:0]  len;
  logic [41:0] occ;
  logic        eat, over, win;

  always #5 clk = ~clk;

  snake_ctrl #(
    .GRID_W (7),
    .GRID_H (6),
    .MAX_LEN(8)
  ) dut (
    .i_Clk      (clk),
    .i_Reset    (rst),
    .i_Tick     (tick),
    .i_Up       (up),
    .i_Down     (down),
    .i_Left     (left),
    .i_Right    (right),
    .i_Apple_X  (ax),
    .i_Apple_Y  (ay),
    .o_Head_X   (hx),
    .o_Head_Y   (hy),
    .o_Length   (len),
    .o_Occupancy(occ),
    .o_Eat      (eat),
    .o_Game_Over(over),
    .o_Win      (win)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  btn;   // {Up, Down, Left, Right}
    logic        tick;
    logic [2:0]  ax, ay;
    logic [2:0]  hx, hy;
    logic [3:0]  len;
    logic        eat, over, win;
    logic        chk_occ;
    logic [41:0] occ;
  } vec_t;

  typedef struct {
    int          row;
    logic [2:0]  hx, hy;
    logic [3:0]  len;
    logic        eat, over, win;
    logic        chk_occ;
    logic [41:0] occ;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void add(input logic r, input logic [3:0] b, input logic t,
                              input int apx, input int apy, input int ex, input int ey,
                              input int el, input logic ee, input logic eo, input logic ew,
                              input logic c = 1'b0, input logic [41:0] o = '0);
    vec_t v;
    v.rst = r; v.btn = b; v.tick = t;
    v.ax = 3'(apx); v.ay = 3'(apy);
    v.hx = 3'(ex); v.hy = 3'(ey); v.len = 4'(el);
    v.eat = ee; v.over = eo; v.win = ew;
    v.chk_occ = c; v.occ = o;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int row, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int row);
    exp_t e;
    rst = v.rst; tick = v.tick;
    up = v.btn[3]; down = v.btn[2]; left = v.btn[1]; right = v.btn[0];
    ax = v.ax; ay = v.ay;
    e.row = row; e.hx = v.hx; e.hy = v.hy; e.len = v.len;
    e.eat = v.eat; e.over = v.over; e.win = v.win;
    e.chk_occ = v.chk_occ; e.occ = v.occ;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("head_x", e.row, 64'(hx), 64'(e.hx));
    check("head_y", e.row, 64'(hy), 64'(e.hy));
    check("length", e.row, 64'(len), 64'(e.len));
    check("eat", e.row, 64'(eat), 64'(e.eat));
    check("game_over", e.row, 64'(over), 64'(e.over));
    check("win", e.row, 64'(win), 64'(e.win));
    if (e.chk_occ) check("occupancy", e.row, 64'(occ), 64'(e.occ));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    ax = '0; ay = '0;

    // Run right into the east wall; tick ignored in IDLE; reset out of OVER.
    add(1, 4'h0, 0, 6, 4, 1, 3, 1, 0, 0, 0, 1, 42'h400000);
    add(0, 4'h0, 1, 6, 4, 1, 3, 1, 0, 0, 0);
    add(0, 4'h1, 0, 6, 4, 1, 3, 1, 0, 0, 0);
    add(0, 4'h0, 1, 6, 4, 2, 3, 1, 0, 0, 0);
    add(0, 4'h0, 1, 6, 4, 3, 3, 1, 0, 0, 0);
    add(0, 4'h0, 1, 6, 4, 4, 3, 1, 0, 0, 0);
    add(0, 4'h0, 1, 6, 4, 5, 3, 1, 0, 0, 0);
    add(0, 4'h0, 1, 6, 4, 6, 3, 1, 0, 0, 0);
    add(0, 4'h0, 1, 6, 4, 6, 3, 1, 0, 1, 0);
    add(0, 4'h0, 1, 6, 4, 6, 3, 1, 0, 1, 0);
    add(1, 4'h0, 1, 6, 4, 1, 3, 1, 0, 0, 0, 1, 42'h400000);
    // First apple, single-cycle eat, then reversal ignored at length 2.
    add(0, 4'h1, 0, 2, 3, 1, 3, 1, 0, 0, 0);
    add(0, 4'h0, 1, 2, 3, 2, 3, 2, 1, 0, 0, 1, 42'hC00000);
    add(0, 4'h0, 0, 0, 0, 2, 3, 2, 0, 0, 0);
    add(0, 4'h2, 0, 0, 0, 2, 3, 2, 0, 0, 0);
    add(0, 4'h0, 1, 0, 0, 3, 3, 2, 0, 0, 0, 1, 42'h1800000);
    // Reversal accepted at length 1.
    add(1, 4'h0, 0, 0, 0, 1, 3, 1, 0, 0, 0);
    add(0, 4'h1, 0, 0, 0, 1, 3, 1, 0, 0, 0);
    add(0, 4'h0, 1, 0, 0, 2, 3, 1, 0, 0, 0);
    add(0, 4'h2, 0, 0, 0, 2, 3, 1, 0, 0, 0);
    add(0, 4'h0, 1, 0, 0, 1, 3, 1, 0, 0, 0);
    // Length 4 in a 2x2 loop: chasing the tail is legal.
    add(1, 4'h0, 0, 0, 0, 1, 3, 1, 0, 0, 0);
    add(0, 4'h1, 0, 2, 3, 1, 3, 1, 0, 0, 0);
    add(0, 4'h0, 1, 2, 3, 2, 3, 2, 1, 0, 0);
    add(0, 4'h0, 1, 3, 3, 3, 3, 3, 1, 0, 0);
    add(0, 4'h0, 1, 4, 3, 4, 3, 4, 1, 0, 0);
    add(0, 4'h4, 0, 0, 0, 4, 3, 4, 0, 0, 0);
    add(0, 4'h0, 1, 0, 0, 4, 4, 4, 0, 0, 0);
    add(0, 4'h2, 0, 0, 0, 4, 4, 4, 0, 0, 0);
    add(0, 4'h0, 1, 0, 0, 3, 4, 4, 0, 0, 0);
    add(0, 4'h8, 0, 0, 0, 3, 4, 4, 0, 0, 0);
    add(0, 4'h0, 1, 0, 0, 3, 3, 4, 0, 0, 0);
    add(0, 4'h1, 0, 0, 0, 3, 3, 4, 0, 0, 0);
    add(0, 4'h0, 1, 0, 0, 4, 3, 4, 0, 0, 0, 1, 42'h183000000);
    // Length 5 in the same loop bites itself; collision beats the apple there.
    add(1, 4'h0, 0, 0, 0, 1, 3, 1, 0, 0, 0);
    add(0, 4'h1, 0, 2, 3, 1, 3, 1, 0, 0, 0);
    add(0, 4'h0, 1, 2, 3, 2, 3, 2, 1, 0, 0);
    add(0, 4'h0, 1, 3, 3, 3, 3, 3, 1, 0, 0);
    add(0, 4'h0, 1, 4, 3, 4, 3, 4, 1, 0, 0);
    add(0, 4'h0, 1, 5, 3, 5, 3, 5, 1, 0, 0);
    add(0, 4'h4, 0, 0, 0, 5, 3, 5, 0, 0, 0);
    add(0, 4'h0, 1, 0, 0, 5, 4, 5, 0, 0, 0);
    add(0, 4'h2, 0, 0, 0, 5, 4, 5, 0, 0, 0);
    add(0, 4'h0, 1, 0, 0, 4, 4, 5, 0, 0, 0);
    add(0, 4'h8, 0, 4, 3, 4, 4, 5, 0, 0, 0);
    add(0, 4'h0, 1, 4, 3, 4, 4, 5, 0, 1, 0);
    // Seven apples to length 8 and WIN; later ticks change nothing.
    add(1, 4'h0, 0, 0, 0, 1, 3, 1, 0, 0, 0);
    add(0, 4'h1, 0, 2, 3, 1, 3, 1, 0, 0, 0);
    add(0, 4'h0, 1, 2, 3, 2, 3, 2, 1, 0, 0);
    add(0, 4'h0, 1, 3, 3, 3, 3, 3, 1, 0, 0);
    add(0, 4'h0, 1, 4, 3, 4, 3, 4, 1, 0, 0);
    add(0, 4'h0, 1, 5, 3, 5, 3, 5, 1, 0, 0);
    add(0, 4'h0, 1, 6, 3, 6, 3, 6, 1, 0, 0);
    add(0, 4'h4, 0, 6, 4, 6, 3, 6, 0, 0, 0);
    add(0, 4'h0, 1, 6, 4, 6, 4, 7, 1, 0, 0);
    add(0, 4'h0, 1, 6, 5, 6, 5, 8, 1, 0, 1, 1, 42'h2040FC00000);
    add(0, 4'h0, 1, 0, 0, 6, 5, 8, 0, 0, 1, 1, 42'h2040FC00000);
    add(0, 4'h1, 1, 6, 5, 6, 5, 8, 0, 0, 1);
    // Button priority (Up over Left/Right, Down over Left/Right) and the north wall.
    add(1, 4'h0, 0, 6, 5, 1, 3, 1, 0, 0, 0);
    add(0, 4'hB, 0, 6, 5, 1, 3, 1, 0, 0, 0);
    add(0, 4'h0, 1, 6, 5, 1, 2, 1, 0, 0, 0);
    add(0, 4'h0, 1, 6, 5, 1, 1, 1, 0, 0, 0);
    add(0, 4'h7, 0, 6, 5, 1, 1, 1, 0, 0, 0);
    add(0, 4'h0, 1, 6, 5, 1, 2, 1, 0, 0, 0);
    add(0, 4'h8, 0, 6, 5, 1, 2, 1, 0, 0, 0);
    add(0, 4'h0, 1, 6, 5, 1, 1, 1, 0, 0, 0);
    add(0, 4'h0, 1, 6, 5, 1, 0, 1, 0, 0, 0);
    add(0, 4'h0, 1, 6, 5, 1, 0, 1, 0, 1, 0);
    // West wall.
    add(1, 4'h0, 0, 6, 5, 1, 3, 1, 0, 0, 0);
    add(0, 4'h2, 0, 6, 5, 1, 3, 1, 0, 0, 0);
    add(0, 4'h0, 1, 6, 5, 0, 3, 1, 0, 0, 0);
    add(0, 4'h0, 1, 6, 5, 0, 3, 1, 0, 1, 0);

    foreach (vecs[i]) apply(vecs[i], i);

    // Reset coincident with an eating tick.
    rst = 1'b1; tick = 1'b0; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; right = 1'b1; ax = 3'd2; ay = 3'd3;
    @(posedge clk); #1;
    right = 1'b0; rst = 1'b1; tick = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_tick_eat", -1, 64'(eat), 64'd0);
    check("rst_tick_head_x", -1, 64'(hx), 64'd1);
    check("rst_tick_head_y", -1, 64'(hy), 64'd3);
    check("rst_tick_length", -1, 64'(len), 64'd1);
    check("rst_tick_occ", -1, 64'(occ), 64'h400000);
    check("rst_tick_over", -1, 64'(over), 64'd0);
    check("rst_tick_win", -1, 64'(win), 64'd0);
    @(posedge clk); #1;
    tick = 1'b0;
    check("idle_after_rst_eat", -2, 64'(eat), 64'd0);
    check("idle_after_rst_head_x", -2, 64'(hx), 64'd1);
    check("idle_after_rst_length", -2, 64'(len), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
